// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the synchronous instruction ROM, pairs each returned word
// with its PC and buffers it in a 2-entry queue, and hands {pc, instr} to decode over valid/ready.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd148,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_word,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic        fault
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] fetch_pc;
   logic        inflight_v;
   logic [31:0] inflight_pc;

   entry_t      q_head;
   entry_t      q_tail;
   logic [1:0]  occ;
   logic [1:0]  occ_next;

   logic        misaligned;
   logic        flush;
   logic        push;
   logic        pop;
   logic        issue;
   entry_t      new_entry;

   assign misaligned = (redirect_target[1:0] != 2'b00);
   assign new_entry  = '{pc: inflight_pc, instr: imem_word};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: HALT is left only through reset.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_next = state;
      if (state == RUN && redirect_valid && misaligned) begin
         state_next = HALT;
      end
   end

   // Per-cycle control: redirect outranks issue, push and pop; HALT freezes everything.
   always_comb begin
      flush    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      issue    = 1'b0;
      occ_next = occ;
      if (state == RUN) begin
         flush    = redirect_valid;
         pop      = dec_valid & dec_ready;
         push     = inflight_v & ~redirect_valid;
         occ_next = occ + {1'b0, push} - {1'b0, pop};
         issue    = ~redirect_valid && (occ_next <= 2'd1);
      end
   end

   // Fetch address and the single outstanding memory read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight_v  <= 1'b0;
         inflight_pc <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         inflight_v <= issue;
         if (flush) begin
            fetch_pc <= redirect_target;
         end else if (issue) begin
            fetch_pc    <= fetch_pc + PC_STEP;
            inflight_pc <= fetch_pc;
         end
      end
   end

   // Two-entry queue; head registers drive decode directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: queue storage is reset because its head is visible on dec_pc/dec_instr out of reset.
         occ    <= 2'd0;
         q_head <= '0;
         q_tail <= '0;
      end else if (flush) begin
         occ <= 2'd0;
      end else begin
         occ <= occ_next;
         unique case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) q_head <= new_entry;
               else             q_tail <= new_entry;
            end
            2'b01: begin
               q_head <= q_tail;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  q_head <= q_tail;
                  q_tail <= new_entry;
               end else begin
                  q_head <= new_entry;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky fault, set on the edge that enters HALT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault <= 1'b0;
      end else if (state_next == HALT) begin
         fault <= 1'b1;
      end
   end

   assign imem_addr = fetch_pc;
   assign dec_valid = (occ != 2'd0);
   assign dec_pc    = q_head.pc;
   assign dec_instr = q_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: ROM model plus a stream scoreboard that expects
// consecutive PCs from each reset/redirect target, each carrying rom(pc).
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'd148;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_word;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: the next PC decode must see, and whether the unit is halted.
   logic [31:0] exp_pc;
   bit          halted;
   logic [31:0] halt_addr;
   bit          flush_pending;
   int          n_accept;
   logic [31:0] last_acc_pc;
   logic [31:0] last_acc_instr;
   bit          seen_valid;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_word       (imem_word),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_instr       (dec_instr),
      .dec_pc          (dec_pc),
      .fault           (fault)
   );

   // ROM contents; 0xC0..0xCF in each 256-byte page reads as zero (unmapped).
   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'd148: return 32'h0000_0513;
         32'd152: return 32'h0000_0593;
         32'd156: return 32'h0000_0613;
         32'd244: return 32'h0047_2283;
         default: begin
            if (a[7:4] == 4'hC) return 32'd0;
            return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
         end
      endcase
   endfunction

   always @(posedge clk) imem_word <= rom(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock period: scoreboard at the falling edge, return 1 time unit after the rising edge.
   task automatic cycle();
      @(negedge clk);
      seen_valid = dec_valid;
      if (!rst) begin
         if (flush_pending) begin
            check("flush_valid_low", {31'd0, dec_valid}, 32'd0);
            flush_pending = 1'b0;
         end
         check("fault", {31'd0, fault}, {31'd0, halted});
         if (halted) begin
            check("halt_valid", {31'd0, dec_valid}, 32'd0);
            check("halt_addr", imem_addr, halt_addr);
         end
         if (dec_valid === 1'b1 && dec_ready) begin
            check("dec_pc", dec_pc, exp_pc);
            check("dec_instr", dec_instr, rom(exp_pc));
            last_acc_pc    = dec_pc;
            last_acc_instr = dec_instr;
            exp_pc         = exp_pc + 32'd4;
            n_accept++;
         end
         if (redirect_valid && !halted) begin
            exp_pc        = redirect_target;
            flush_pending = 1'b1;
            if (redirect_target[1:0] != 2'b00) begin
               halted    = 1'b1;
               halt_addr = redirect_target;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_pc        = RESET_PC;
      halted        = 1'b0;
      flush_pending = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid  = 1'b1;
      redirect_target = target;
      cycle();
      redirect_valid  = 1'b0;
   endtask

   // Bounded wait for the next accepted entry, then check its PC.
   task automatic expect_next_accept(input string tag, input logic [31:0] pc);
      int n0;
      n0 = n_accept;
      for (int i = 0; i < 20 && n_accept == n0; i++) cycle();
      check({tag, "_arrived"}, {31'd0, n_accept != n0}, 32'd1);
      check(tag, last_acc_pc, pc);
   endtask

   initial begin
      logic [31:0] frz_addr, frz_pc, frz_instr;
      int          n0;

      rst             = 1'b1;
      dec_ready       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;
      n_accept        = 0;
      model_reset();

      // Reset values.
      #2;
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_valid", {31'd0, dec_valid}, 32'd0);
      check("rst_pc", dec_pc, 32'd0);
      check("rst_instr", dec_instr, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      dec_ready = 1'b1;
      model_reset();

      // Latency: dec_valid first high in cycle 2, then one handshake per cycle.
      cycle();
      check("lat_c0_valid", {31'd0, seen_valid}, 32'd0);
      cycle();
      check("lat_c1_valid", {31'd0, seen_valid}, 32'd0);
      cycle();
      check("lat_c2_valid", {31'd0, seen_valid}, 32'd1);
      cycle();
      cycle();
      check("first_three_accepts", n_accept, 32'd3);
      check("third_instr", last_acc_instr, 32'h0000_0613);
      repeat (4) cycle();

      // Backpressure: head and address freeze, stream resumes without skip or duplicate.
      frz_addr  = imem_addr;
      frz_pc    = dec_pc;
      frz_instr = dec_instr;
      dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_addr", imem_addr, frz_addr);
         check("bp_pc", dec_pc, frz_pc);
         check("bp_instr", dec_instr, frz_instr);
         check("bp_valid", {31'd0, dec_valid}, 32'd1);
      end
      dec_ready = 1'b1;
      n0 = n_accept;
      repeat (8) cycle();
      check("bp_resume_count", n_accept - n0, 32'd8);

      // Redirect to 244 with a full queue; the redirect-cycle handshake still counts.
      dec_ready = 1'b0;
      cycle();
      dec_ready = 1'b1;
      redirect(32'd244);
      check("redir_addr", imem_addr, 32'd244);
      expect_next_accept("redir_244_pc", 32'd244);
      check("redir_244_instr", last_acc_instr, 32'h0047_2283);
      repeat (4) cycle();

      // Redirect under backpressure, then a second one: only the 204 stream survives.
      dec_ready = 1'b0;
      repeat (3) cycle();
      redirect(32'd400);
      redirect(32'd204);
      dec_ready = 1'b1;
      expect_next_accept("redir_204_pc", 32'd204);
      check("zero_word_passthrough", last_acc_instr, 32'd0);
      repeat (6) cycle();

      // Address wrap at the top of the 32-bit space.
      redirect(32'hFFFF_FFF8);
      repeat (6) cycle();
      check("wrap_stream", {31'd0, exp_pc > 32'd0 && exp_pc < 32'd16}, 32'd1);

      // Random ready and aligned redirects.
      for (int i = 0; i < 400; i++) begin
         dec_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) redirect($urandom_range(0, 16'hFFFF) & 32'hFFFF_FFFC);
         else cycle();
      end
      dec_ready = 1'b1;
      repeat (6) cycle();

      // Misaligned redirect: sticky fault, halt for 20 cycles, later redirects ignored.
      redirect(32'h0000_0102);
      for (int i = 0; i < 20; i++) begin
         if (i == 10) redirect(32'h0000_0200);
         else cycle();
      end
      check("halt_addr_final", imem_addr, 32'h0000_0102);
      rst = 1'b1;
      #1;
      check("halt_rst_fault", {31'd0, fault}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      expect_next_accept("post_halt_pc", RESET_PC);
      repeat (6) cycle();

      // Asynchronous reset in mid-cycle while streaming.
      #2;
      rst = 1'b1;
      #1;
      check("async_addr", imem_addr, RESET_PC);
      check("async_valid", {31'd0, dec_valid}, 32'd0);
      check("async_pc", dec_pc, 32'd0);
      check("async_fault", {31'd0, fault}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      expect_next_accept("post_async_pc", RESET_PC);
      repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
